nes_joypad: RTL and testbench

- Emulates the two standard NES controller serial ports (4021 shift-register behaviour) and sits directly downstream of the CPU/APU wrapper.
- Consumes that wrapper's controller latch bit (ctrl_strobe[0]) and per-port read pulses (ctrl_out[1:0]).
- Returns the serial button bit on ctrl_data[1:0].
- Button sources are raw asynchronous parallel inputs (board GPIO/USB bridge); each is synchronized and debounced here.

---
 rtl/nes_joypad.sv | 79 +++++++
 tb/tb_nes_joypad.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad.sv
// nes_joypad: two NES controller ports with synchronized, debounced buttons and 4021-style serial readout
module nes_joypad #(
  parameter int          SYNC_STAGES     = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter bit          BLOCK_OPPOSING  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe_i,
  input  logic [1:0]  read_i,
  input  logic [7:0]  btn_p1_i,
  input  logic [7:0]  btn_p2_i,
  output logic [1:0]  ctrl_data_o,
  output logic [15:0] btn_state_o
);
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] synced;
  logic [15:0] db;
  logic [15:0] db_cnt [16];
  logic [7:0]  sr [2];
  logic [3:0]  sr_cnt [2];
  assign synced = sync_q[SYNC_STAGES-1];
  assign ctrl_data_o = {sr[1][0], sr[0][0]};
  function automatic logic [7:0] filt(input logic [7:0] b);
    logic ud, lr;
    ud = BLOCK_OPPOSING && b[4] && b[5];
    lr = BLOCK_OPPOSING && b[6] && b[7];
    return {b[7:6] & {2{!lr}}, b[5:4] & {2{!ud}}, b[3:0]};
  endfunction
  // multi-flop synchronizer for the asynchronous button inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {btn_p2_i, btn_p1_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  // per-bit debounce: accept a new level only after it has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '0;
      for (int b = 0; b < 16; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 16; b++) begin
        if (DEBOUNCE_CYCLES == 16'd0) db[b] <= synced[b];
        else if (synced[b] == db[b]) db_cnt[b] <= '0;
        else if (db_cnt[b] == DEBOUNCE_CYCLES - 16'd1) begin
          db[b] <= synced[b];
          db_cnt[b] <= '0;
        end else db_cnt[b] <= db_cnt[b] + 16'd1;
      end
    end
  end
  // registered opposing-direction filter output
  always_ff @(posedge clk) begin
    if (rst) btn_state_o <= '0;
    else btn_state_o <= {filt(db[15:8]), filt(db[7:0])};
  end
  // per-port parallel load while strobed, shift in ones on each read otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        sr[p] <= '0;
        sr_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (strobe_i) begin
          sr[p] <= btn_state_o[p*8 +: 8];
          sr_cnt[p] <= '0;
        end else if (read_i[p]) begin
          sr[p] <= {1'b1, sr[p][7:1]};
          sr_cnt[p] <= (sr_cnt[p] == 4'd8) ? 4'd8 : sr_cnt[p] + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_nes_joypad.sv
// tb_nes_joypad: model-checked bench for two joypad configurations driven by shared stimulus
module tb_nes_joypad;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic [1:0]  rd_p = 2'b00;
  logic [7:0]  p1 = 8'h00;
  logic [7:0]  p2 = 8'h00;
  logic [1:0]  d0, d1;
  logic [15:0] s0, s1;
  int n_cmp = 0;
  int n_bad = 0;
  bit live = 1'b0;
  always #5 clk = ~clk;
  nes_joypad #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16'd0), .BLOCK_OPPOSING(1'b0)) u0 (
    .clk(clk), .rst(rst), .strobe_i(strobe), .read_i(rd_p),
    .btn_p1_i(p1), .btn_p2_i(p2), .ctrl_data_o(d0), .btn_state_o(s0));
  nes_joypad #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16'd4), .BLOCK_OPPOSING(1'b1)) u1 (
    .clk(clk), .rst(rst), .strobe_i(strobe), .read_i(rd_p),
    .btn_p1_i(p1), .btn_p2_i(p2), .ctrl_data_o(d1), .btn_state_o(s1));
  int          dbn [2] = '{0, 4};
  bit          blk [2] = '{1'b0, 1'b1};
  logic [15:0] hq [$];
  logic [15:0] mdb [2];
  logic [15:0] mst [2];
  int          streak [2][16];
  logic [7:0]  lat [2][2];
  int          rc [2][2];
  logic [1:0]  xd [2];
  logic [15:0] s_in, odb, ost;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] mf(input logic [7:0] b, input bit bl);
    logic [7:0] r;
    r = b;
    if (bl && b[4] && b[5]) r[5:4] = 2'b00;
    if (bl && b[6] && b[7]) r[7:6] = 2'b00;
    return r;
  endfunction
  // model: delayed raw samples, stability streaks, latched byte plus read index
  always @(posedge clk) begin
    if (rst) begin
      live = 1'b1;
      hq = {16'h0, 16'h0};
      for (int i = 0; i < 2; i++) begin
        mdb[i] = '0;
        mst[i] = '0;
        xd[i] = '0;
        for (int b = 0; b < 16; b++) streak[i][b] = 0;
        for (int p = 0; p < 2; p++) begin
          lat[i][p] = '0;
          rc[i][p] = 0;
        end
      end
    end else begin
      s_in = hq.pop_front();
      hq.push_back({p2, p1});
      for (int i = 0; i < 2; i++) begin
        odb = mdb[i];
        ost = mst[i];
        for (int b = 0; b < 16; b++) begin
          if (dbn[i] == 0) mdb[i][b] = s_in[b];
          else if (s_in[b] == odb[b]) streak[i][b] = 0;
          else begin
            streak[i][b]++;
            if (streak[i][b] == dbn[i]) begin
              mdb[i][b] = s_in[b];
              streak[i][b] = 0;
            end
          end
        end
        mst[i] = {mf(odb[15:8], blk[i]), mf(odb[7:0], blk[i])};
        for (int p = 0; p < 2; p++) begin
          if (strobe) begin
            lat[i][p] = ost[p*8 +: 8];
            rc[i][p] = 0;
          end else if (rd_p[p] && rc[i][p] < 8) rc[i][p]++;
          xd[i][p] = (rc[i][p] >= 8) ? 1'b1 : lat[i][p][rc[i][p]];
        end
      end
    end
  end
  // compare both instances against the model on every cycle after reset
  always @(negedge clk) begin
    if (live) begin
      chk("u0_data", {14'h0, d0}, {14'h0, xd[0]});
      chk("u0_state", s0, mst[0]);
      chk("u1_data", {14'h0, d1}, {14'h0, xd[1]});
      chk("u1_state", s1, mst[1]);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rd(input int p, input logic e, input string nm);
    @(negedge clk);
    rd_p[p] = 1'b1;
    chk(nm, {15'h0, d0[p]}, {15'h0, e});
    chk({nm, "_model"}, {15'h0, xd[0][p]}, {15'h0, e});
    @(negedge clk);
    rd_p = 2'b00;
    cyc(2);
  endtask
  task automatic latch();
    @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask
  logic [9:0] seq1 = 10'b1110000101;
  initial begin
    cyc(3);
    chk("rst_data", {14'h0, d0}, 16'h0);
    chk("rst_state", s0, 16'h0);
    rst = 1'b0;
    p1 = 8'h85;
    cyc(12);
    latch();
    for (int k = 0; k < 10; k++) rd(0, seq1[k], $sformatf("seq85_%0d", k));
    chk("u1_seq_state", s1, 16'h0085);
    p1 = 8'h01;
    @(negedge clk);
    strobe = 1'b1;
    cyc(12);
    for (int k = 0; k < 5; k++) rd(0, 1'b1, $sformatf("strobed_%0d", k));
    p1 = 8'h00;
    cyc(8);
    chk("strobed_release", {15'h0, d0[0]}, 16'h0);
    strobe = 1'b0;
    p1 = 8'h01;
    p2 = 8'h02;
    cyc(12);
    latch();
    rd(1, 1'b0, "p2_r0");
    rd(1, 1'b1, "p2_r1");
    rd(1, 1'b0, "p2_r2");
    rd(0, 1'b1, "p1_first");
    p1 = 8'h00;
    p2 = 8'h00;
    cyc(12);
    for (int k = 0; k < 20; k++) begin
      p1[0] = ~p1[0];
      cyc(2);
    end
    chk("bounce_u1", {15'h0, s1[0]}, 16'h0);
    p1[0] = 1'b1;
    cyc(12);
    chk("settle_u1", {15'h0, s1[0]}, 16'h1);
    p1 = 8'h31;
    cyc(14);
    chk("block_u1", {8'h0, s1[7:0]}, 16'h0001);
    chk("noblock_u0", {8'h0, s0[7:0]}, 16'h0031);
    p1 = 8'h11;
    cyc(14);
    chk("release_u1", {8'h0, s1[7:0]}, 16'h0011);
    p1 = 8'h85;
    cyc(12);
    @(negedge clk);
    strobe = 1'b1;
    rd_p = 2'b01;
    @(negedge clk);
    strobe = 1'b0;
    rd_p = 2'b00;
    chk("overlap_noshift", {15'h0, d0[0]}, 16'h1);
    @(negedge clk);
    chk("fall_hold", {15'h0, d0[0]}, 16'h1);
    rd(0, 1'b1, "ov_r0");
    rd(0, 1'b0, "ov_r1");
    rd(0, 1'b1, "ov_r2");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_u0", {14'h0, d0}, 16'h0);
    chk("midrst_u1", {14'h0, d1}, 16'h0);
    chk("midrst_state", s0, 16'h0);
    cyc(12);
    latch();
    rd(0, 1'b1, "relatch_A");
    rd(0, 1'b0, "relatch_B");
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
